// File: rtl/data_mem_rmw.sv
// Data memory for the MEM stage: byte/half/word loads and stores, RMW for sub-word stores, LED register.
// Optional: define DATA_MEM_LED_READBACK_EN so that loads from LED_ADDR return the LED register.
module data_mem_rmw #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned ADDR_BITS   = 10,
   parameter logic [31:0] LED_ADDR    = 32'h2000,
   parameter int unsigned LED_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          addr,
   input  logic [31:0]          write_data,
   input  logic                 memwrite,
   input  logic                 memread,
   input  logic [3:0]           sign_mask,
   output logic [31:0]          read_data,
   output logic [LED_WIDTH-1:0] led,
   output logic                 clk_stall,
   output logic                 misalign_err
);

   localparam int unsigned BUF_AW = ADDR_BITS + 2;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RMW_READ, S_RMW_WRITE} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_t;

   state_t              r_state;
   size_t               r_size;
   logic                r_sign;
   logic [BUF_AW-1:0]   r_addr;
   logic [15:0]         r_wdata;
   logic [31:0]         r_word;
   logic [31:0]         r_ram_q;
   logic [31:0]         r_ram [DEPTH_WORDS];

   size_t               w_size;
   logic                w_idle;
   logic                w_req;
   logic                w_misalign;
   logic                w_bad;
   logic                w_is_led;
   logic                w_led_rb;
   logic                w_word_wr;
   logic                w_rmw_wr;
   logic                w_ram_we;
   logic [ADDR_BITS-1:0] w_idx_in;
   logic [ADDR_BITS-1:0] w_idx_buf;
   logic [ADDR_BITS-1:0] w_ram_waddr;
   logic [ADDR_BITS-1:0] w_ram_raddr;
   logic [31:0]         w_ram_wdata;
   logic [31:0]         w_merged;

   // Field selection plus zero/sign extension for a load result.
   function automatic logic [31:0] f_extract(input logic [31:0] w, input size_t sz,
                                             input logic sgn, input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (sz)
         SZ_W:    res = w;
         SZ_H:    res = {{16{sgn & h[15]}}, h};
         default: res = {{24{sgn & b[7]}}, b};
      endcase
      return res;
   endfunction

   // Replace only the addressed byte or half of the fetched word.
   function automatic logic [31:0] f_merge(input logic [31:0] w, input logic [15:0] d,
                                           input size_t sz, input logic [1:0] off);
      logic [31:0] res;
      res = w;
      if (sz == SZ_H) begin
         if (off[1]) res[31:16] = d;
         else        res[15:0]  = d;
      end else begin
         res[{off, 3'b000} +: 8] = d[7:0];
      end
      return res;
   endfunction

   always_comb begin
      w_size = SZ_BAD;
      if (sign_mask[2])      w_size = SZ_W;
      else if (sign_mask[1]) w_size = SZ_H;
      else if (sign_mask[0]) w_size = SZ_B;
   end

   assign w_idle     = (r_state == S_IDLE);
   assign w_req      = memread | memwrite;
   assign w_misalign = ((w_size == SZ_W) && (addr[1:0] != 2'b00)) ||
                       ((w_size == SZ_H) && addr[0]) || (w_size == SZ_BAD);
   assign w_bad      = (memread & memwrite) | w_misalign;
   assign w_is_led   = (addr == LED_ADDR);
`ifdef DATA_MEM_LED_READBACK_EN
   assign w_led_rb   = w_is_led;
`else
   assign w_led_rb   = 1'b0;
`endif

   assign w_idx_in    = addr[ADDR_BITS+1:2];
   assign w_idx_buf   = r_addr[ADDR_BITS+1:2];
   assign w_word_wr   = w_idle & memwrite & ~w_bad & ~w_is_led & (w_size == SZ_W);
   assign w_rmw_wr    = (r_state == S_RMW_WRITE);
   // Gated by rst_n so a reset that lands on the write edge aborts the RMW.
   assign w_ram_we    = rst_n & (w_word_wr | w_rmw_wr);
   assign w_merged    = f_merge(r_word, r_wdata, r_size, r_addr[1:0]);
   assign w_ram_waddr = w_rmw_wr ? w_idx_buf : w_idx_in;
   assign w_ram_wdata = w_rmw_wr ? w_merged : write_data;
   assign w_ram_raddr = w_idle ? w_idx_in : w_idx_buf;

   // Synchronous block RAM, contents not reset.
   always_ff @(posedge clk) begin
      if (w_ram_we) r_ram[w_ram_waddr] <= w_ram_wdata;
      r_ram_q <= r_ram[w_ram_raddr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_size       <= SZ_B;
         r_sign       <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_word       <= '0;
         read_data    <= '0;
         led          <= '0;
         clk_stall    <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_addr  <= addr[BUF_AW-1:0];
                  r_wdata <= write_data[15:0];
                  r_size  <= w_size;
                  r_sign  <= sign_mask[3];
                  if (w_bad) begin
                     misalign_err <= 1'b1;
                     if (memread) read_data <= '0;
                  end else if (memwrite) begin
                     if (w_is_led) begin
                        led <= write_data[LED_WIDTH-1:0];
                     end else if (w_size != SZ_W) begin
                        clk_stall <= 1'b1;
                        r_state   <= S_RMW_READ;
                     end
                  end else if (w_led_rb) begin
                     read_data <= 32'(led);
                  end else begin
                     clk_stall <= 1'b1;
                     r_state   <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               read_data <= f_extract(r_ram_q, r_size, r_sign, r_addr[1:0]);
               clk_stall <= 1'b0;
               r_state   <= S_IDLE;
            end
            S_RMW_READ: begin
               r_word  <= r_ram_q;
               r_state <= S_RMW_WRITE;
            end
            S_RMW_WRITE: begin
               clk_stall <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_rmw.sv
// Scoreboard bench for data_mem_rmw: directed test-plan cases plus random traffic against a word-array model.
module tb_data_mem_rmw;

   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] LED_A = 32'h2000;
   localparam logic [3:0]  M_W = 4'b0100, M_H = 4'b0010, M_B = 4'b0001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] write_data = '0;
   logic        memwrite = 1'b0;
   logic        memread = 1'b0;
   logic [3:0]  sign_mask = '0;
   logic [31:0] read_data;
   logic [7:0]  led;
   logic        clk_stall;
   logic        misalign_err;

   always #5 clk = ~clk;

   data_mem_rmw #(.DEPTH_WORDS(DEPTH), .ADDR_BITS(10), .LED_ADDR(LED_A), .LED_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .write_data(write_data),
      .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
      .read_data(read_data), .led(led), .clk_stall(clk_stall), .misalign_err(misalign_err)
   );

   typedef struct {
      logic [31:0] rdata;
      int          stall;
      logic [7:0]  led;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;

   logic [31:0] m_mem [int unsigned];
   logic [31:0] m_rdata = '0;
   logic [7:0]  m_led = '0;
   logic        m_err = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference behaviour: byte-addressed arithmetic on a word array.
   task automatic model_op(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m, output int stall);
      int unsigned size, idx, off;
      logic [31:0] fmask, v;
      size  = m[2] ? 4 : (m[1] ? 2 : 1);
      idx   = (a / 4) % DEPTH;
      off   = a % 4;
      fmask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
      stall = 0;
      if ((rd && wr) || ((a % size) != 0)) begin
         m_err = 1'b1;
         if (rd) m_rdata = '0;
      end else if (wr) begin
         if (a == LED_A) m_led = d[7:0];
         else if (size == 4) m_mem[idx] = d;
         else begin
            m_mem[idx] = (m_mem[idx] & ~(fmask << (8 * off))) | ((d & fmask) << (8 * off));
            stall = 2;
         end
      end else begin
`ifdef DATA_MEM_LED_READBACK_EN
         if (a == LED_A) m_rdata = {24'h0, m_led};
         else
`endif
         begin
            v = (m_mem[idx] >> (8 * off)) & fmask;
            if (size < 4 && m[3] && v[8 * size - 1]) v = v | ~fmask;
            m_rdata = v;
            stall = 1;
         end
      end
   endtask

   task automatic push_exp(input int stall);
      exp_t e;
      e.rdata = m_rdata;
      e.stall = stall;
      e.led   = m_led;
      e.err   = m_err;
      exp_q.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge after the access completes.
   task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
      int st, n;
      model_op(rd, wr, a, d, m, st);
      push_exp(st);
      memread = rd; memwrite = wr; addr = a; write_data = d; sign_mask = m;
      @(negedge clk);
      n = 0;
      while (clk_stall && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) begin
         errors++; checks++;
         $display("FAIL stall_timeout: clk_stall still %b after %0d cycles, required 0", clk_stall, n);
      end
      memread = 1'b0; memwrite = 1'b0;
   endtask

   task automatic model_reset();
      m_rdata = '0; m_led = '0; m_err = 1'b0;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: detects an accepted request, measures its stall, then scores the response.
   initial begin
      forever begin
         @(posedge clk);
         if (rst_n && (memread || memwrite) && !clk_stall) begin
            int   cnt;
            exp_t e;
            #1;
            cnt = 0;
            while (clk_stall && cnt < 8) begin
               cnt++;
               @(posedge clk);
               #1;
            end
            if (exp_q.size() == 0) begin
               errors++; checks++;
               $display("FAIL scoreboard: response seen with no expected entry (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check("read_data", read_data, e.rdata);
               check("stall_cycles", 32'(cnt), 32'(e.stall));
               check("led", 32'(led), 32'(e.led));
               check("misalign_err", 32'(misalign_err), 32'(e.err));
            end
         end
      end
   end

   initial begin
      int st;
      repeat (3) @(negedge clk);
      check("reset_read_data", read_data, 32'h0);
      check("reset_clk_stall", 32'(clk_stall), 32'h0);
      check("reset_led", 32'(led), 32'h0);
      check("reset_misalign_err", 32'(misalign_err), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(0, 1, 32'h00, 32'hCAFE_F00D, M_W);
      do_op(0, 1, 32'h10, 32'hDEAD_BEEF, M_W);
      do_op(1, 0, 32'h10, 32'h0, M_W);
      do_op(0, 1, 32'h10, 32'h1122_3344, M_W);
      do_op(0, 1, 32'h11, 32'h0000_0080, M_B);
      do_op(1, 0, 32'h10, 32'h0, M_W);
      do_op(1, 0, 32'h11, 32'h0, 4'b1001);
      do_op(1, 0, 32'h11, 32'h0, 4'b0001);
      do_op(0, 1, 32'h20, 32'h0, M_W);
      do_op(0, 1, 32'h22, 32'h0000_BEEF, M_H);
      do_op(1, 0, 32'h20, 32'h0, M_W);
      do_op(1, 0, 32'h22, 32'h0, 4'b1010);
      do_op(1, 0, 32'h13, 32'h0, M_W);
      do_op(1, 1, 32'h20, 32'hFFFF_FFFF, M_W);
      do_op(1, 0, 32'h20, 32'h0, M_W);
      reset_pulse();
      check("err_after_reset", 32'(misalign_err), 32'h0);
      do_op(0, 1, LED_A, 32'h0000_00A5, M_W);
      do_op(1, 0, 32'h00, 32'h0, M_W);
      do_op(1, 0, LED_A, 32'h0, M_W);
      do_op(0, 1, 32'h10 + DEPTH * 4, 32'h0BAD_C0DE, M_W);
      do_op(1, 0, 32'h10, 32'h0, M_W);

      // Abort a byte RMW by resetting while it is in its read phase.
      do_op(0, 1, 32'h30, 32'h5566_7788, M_W);
      model_reset();
      push_exp(1);
      memwrite = 1'b1; addr = 32'h31; write_data = 32'h99; sign_mask = M_B;
      @(negedge clk);
      rst_n = 1'b0; memwrite = 1'b0;
      @(negedge clk);
      check("abort_clk_stall", 32'(clk_stall), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      do_op(1, 0, 32'h30, 32'h0, M_W);

      for (int i = 0; i < 16; i++) do_op(0, 1, 32'(i * 4), $urandom, M_W);
      for (int i = 0; i < 300; i++) begin
         int unsigned r, sz, off, idx;
         logic [31:0] a;
         logic [3:0]  m;
         r   = $urandom_range(0, 19);
         sz  = $urandom_range(0, 2);
         idx = $urandom_range(0, 15);
         off = $urandom_range(0, 3);
         if ($urandom_range(0, 9) < 7) off = (sz == 2) ? 0 : ((sz == 1) ? (off & 2) : off);
         m = {1'($urandom_range(0, 1)), 3'(1 << sz)};
         a = 32'(idx * 4 + off) + 32'($urandom_range(0, 3) * DEPTH * 4);
         if ($urandom_range(0, 15) == 0) a = LED_A;
         if (r < 9)       do_op(1, 0, a, $urandom, m);
         else if (r < 18) do_op(0, 1, a, $urandom, m);
         else             do_op(1, 1, a, $urandom, m);
      end

      st = 0;
      while (exp_q.size() != 0 && st < 20) begin
         @(negedge clk);
         st++;
      end
      if (exp_q.size() != 0) begin
         errors++; checks++;
         $display("FAIL drain: %0d expected responses never seen, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_mem_rmw.md
Name: data_mem_rmw

Overview:
Parametrised successor to the single-port data memory. It serves byte, halfword and word loads and stores from a synchronous block RAM of configurable depth. Sub-word stores use a two-cycle read-modify-write, and misaligned or conflicting requests are detected. It sits on the processor's MEM stage, holds the pipeline through clk_stall, and includes the memory-mapped LED register.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in data RAM (power of 2, ≥ 4)
ADDR_BITS, 10, log2(DEPTH_WORDS); word index = addr[ADDR_BITS+1:2]
LED_ADDR, 32'h2000, byte address of LED register
LED_WIDTH, 8, width of led output / LED register

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
addr  input  32  byte address of request
write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
memwrite  input  1  store request, sampled only in IDLE
memread  input  1  load request, sampled only in IDLE
sign_mask  input  4  [3]=sign-extend load, [2]=word, [1]=half, [0]=byte (one-hot in [2:0])
read_data  output  32  load result, registered
led  output  LED_WIDTH  LED register contents
clk_stall  output  1  registered; high while an access occupies extra cycles
misalign_err  output  1  sticky error flag

Behaviour:
- Reset (rst_n low, async): state=IDLE, read_data=0, clk_stall=0, led=0, misalign_err=0.
  - RAM contents are not reset.
  - An in-flight RMW is aborted; no RAM write is performed.
- States: IDLE, LOAD, RMW_READ, RMW_WRITE. In IDLE, latch addr, write_data and sign_mask into internal buffers on every accepted request.
- Misaligned request: half at byte offset 1/3, or word at offset ≠ 0.
  - No RAM or LED access.
  - misalign_err<=1.
  - A load sets read_data<=0.
  - Stays in IDLE with no stall.
- Both memread and memwrite high: treated as a conflict, same handling as misaligned.
- Word store, aligned, addr≠LED_ADDR: RAM written at the IDLE edge. No stall, stays in IDLE.
- Store to LED_ADDR, any size: led_reg<=write_data[LED_WIDTH-1:0] at the IDLE edge. No RAM write, no stall.
- Load: on the IDLE edge, issue the RAM read and set clk_stall<=1, state->LOAD. On the LOAD edge:
  - read_data<=extracted value, clk_stall<=0, ->IDLE.
  - Latency: read_data is valid 2 edges after request; stall is high for exactly 1 cycle.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Zero-extend if sign_mask[3]=0, else sign-extend from the MSB of the selected field.
  - Word loads ignore sign_mask[3].
- Sub-word store, not LED:
  - IDLE edge: issue RAM read, clk_stall<=1, ->RMW_READ.
  - RMW_READ edge: word buffer captures the RAM word, ->RMW_WRITE.
  - RMW_WRITE edge: write merged word (only the addressed byte/half replaced), clk_stall<=0, ->IDLE.
  - Stall is high for 2 cycles.
- Address decoding:
  - Upper address bits above ADDR_BITS+1 are ignored for RAM indexing, so accesses wrap modulo DEPTH_WORDS.
  - LED_ADDR decode uses the full 32 bits.
- Requests arriving while state ≠ IDLE are ignored. The processor must hold them stable while clk_stall is high.
- read_data holds its value between loads; stores never change it.

Optional Feature:
DATA_MEM_LED_READBACK_EN
- Defined: a load from LED_ADDR returns led_reg zero-extended to 32 bits. It completes in IDLE with no stall (read_data updated at the IDLE edge) and the RAM is not read.
- Undefined: a load from LED_ADDR reads RAM word index LED_ADDR[ADDR_BITS+1:2] as a normal 2-cycle load.

Test Plan:
- Word store then load: store 32'hDEADBEEF @0x10 (sign_mask 4'b0100), then load word @0x10 -> no stall on store; stall 1 cycle on load; read_data=32'hDEADBEEF.
- Byte RMW with sign extension:
  - Store byte 8'h80 @0x11 over 32'h11223344 -> RAM word becomes 32'h11228044; stall 2 cycles.
  - Load byte @0x11, sign_mask 4'b1001 -> read_data=32'hFFFFFF80.
  - Same load with sign_mask 4'b0001 -> read_data=32'h00000080.
- Halfword lanes: store half 16'hBEEF @0x22 over 32'h00000000 -> word=32'hBEEF0000. Load half @0x22 signed -> read_data=32'hFFFFBEEF.
- Misaligned and conflict:
  - Load word @0x13 -> read_data=0, misalign_err=1, no stall.
  - memread=memwrite=1 @0x20 -> RAM at 0x20 unchanged, misalign_err stays 1.
  - Pulse rst_n low -> misalign_err=0.
- LED path: store 32'h000000A5 @0x2000 -> led=8'hA5, RAM unchanged.
  - With DATA_MEM_LED_READBACK_EN: load @0x2000 returns 32'h000000A5 with no stall.
- Reset mid-RMW: assert rst_n low during RMW_READ of a byte store @0x30 -> clk_stall=0, state IDLE, RAM word @0x30 unchanged.
